seq_detect_ctrl: RTL and testbench

- Controller and scheduler for a programmable Moore-style serial pattern detector.
- Accepts a pattern configuration and a frame of parallel words over a valid/ready handshake, and serializes each word MSB-first into the detector datapath, one bit per clock.
- Counts matches in overlapping or non-overlapping mode and reports a done pulse with the final count.
- Sits between a word-oriented producer and the bit-serial detection logic.

---
 rtl/seq_detect_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_seq_detect_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_ctrl.sv
// Word-to-bit scheduler and Moore pattern detector with frame-level match counting.
// Optional FIRST_MATCH_POS_EN adds first_pos/first_vld reporting of the first match in a frame.
module seq_detect_ctrl #(
    parameter int PAT_MAX = 8,
    parameter int WORD_W  = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = $clog2(PAT_MAX) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [PAT_MAX-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               start,
    input  logic               word_valid,
    input  logic [WORD_W-1:0]  word_data,
    input  logic               word_last,
    output logic               word_ready,
    output logic               bit_out,
    output logic               bit_valid,
    output logic               match,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               busy,
    output logic               done
`ifdef FIRST_MATCH_POS_EN
    ,
    output logic [15:0]        first_pos,
    output logic               first_vld
`endif
);

    localparam int BC_W = $clog2(WORD_W) + 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        SHIFT = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t             state_r, state_nxt;
    logic [WORD_W-1:0]  sh_r, sh_nxt;
    logic               last_r, last_nxt;
    logic [BC_W-1:0]    bit_cnt_r, bit_cnt_nxt;
    logic [PAT_MAX-2:0] hist_r, hist_nxt;
    logic [LEN_W-1:0]   hist_cnt_r, hist_cnt_nxt;
    logic [CNT_W-1:0]   cnt_r, cnt_nxt;
    logic [PAT_MAX-1:0] pat_r, pat_nxt;
    logic [LEN_W-1:0]   len_r, len_nxt;
    logic               ovl_r, ovl_nxt;
    logic [PAT_MAX-1:0] hist_upd_s;
    logic [PAT_MAX-1:0] mask_s;
    logic               hit_s;

    function automatic logic [PAT_MAX-1:0] len_mask(input logic [LEN_W-1:0] len);
        logic [PAT_MAX-1:0] m;
        for (int i = 0; i < PAT_MAX; i++) begin
            m[i] = (i < int'(len));
        end
        return m;
    endfunction

    // Hit evaluation on the bit being presented this cycle.
    always_comb begin
        hist_upd_s = {hist_r, sh_r[WORD_W-1]};
        mask_s     = len_mask(len_r);
        hit_s      = (state_r == SHIFT) && (len_r != {LEN_W{1'b0}}) &&
                     (({1'b0, hist_cnt_r} + {{LEN_W{1'b0}}, 1'b1}) >= {1'b0, len_r}) &&
                     ((hist_upd_s & mask_s) == (pat_r & mask_s));
    end

    // Next-state and datapath update.
    always_comb begin
        state_nxt    = state_r;
        sh_nxt       = sh_r;
        last_nxt     = last_r;
        bit_cnt_nxt  = bit_cnt_r;
        hist_nxt     = hist_r;
        hist_cnt_nxt = hist_cnt_r;
        cnt_nxt      = cnt_r;
        pat_nxt      = pat_r;
        len_nxt      = len_r;
        ovl_nxt      = ovl_r;
        case (state_r)
            IDLE: begin
                if (cfg_we) begin
                    pat_nxt = cfg_pattern;
                    len_nxt = (cfg_len > LEN_W'(PAT_MAX)) ? LEN_W'(PAT_MAX) : cfg_len;
                    ovl_nxt = cfg_overlap;
                end else begin
                    pat_nxt = pat_r;
                end
                if (start) begin
                    state_nxt    = FETCH;
                    cnt_nxt      = {CNT_W{1'b0}};
                    hist_cnt_nxt = {LEN_W{1'b0}};
                    hist_nxt     = {(PAT_MAX-1){1'b0}};
                end else begin
                    state_nxt = IDLE;
                end
            end
            FETCH: begin
                if (word_valid) begin
                    sh_nxt      = word_data;
                    last_nxt    = word_last;
                    bit_cnt_nxt = {BC_W{1'b0}};
                    state_nxt   = SHIFT;
                end else begin
                    state_nxt = FETCH;
                end
            end
            SHIFT: begin
                sh_nxt      = {sh_r[WORD_W-2:0], 1'b0};
                bit_cnt_nxt = bit_cnt_r + {{(BC_W-1){1'b0}}, 1'b1};
                hist_nxt    = hist_upd_s[PAT_MAX-2:0];
                // Non-overlapping mode forgets the bits that formed the match.
                if (hit_s && !ovl_r) begin
                    hist_cnt_nxt = {LEN_W{1'b0}};
                end else if (hist_cnt_r < LEN_W'(PAT_MAX)) begin
                    hist_cnt_nxt = hist_cnt_r + {{(LEN_W-1){1'b0}}, 1'b1};
                end else begin
                    hist_cnt_nxt = hist_cnt_r;
                end
                if (hit_s && (cnt_r != {CNT_W{1'b1}})) begin
                    cnt_nxt = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    cnt_nxt = cnt_r;
                end
                if (bit_cnt_r == BC_W'(WORD_W - 1)) begin
                    state_nxt = last_r ? FLUSH : FETCH;
                end else begin
                    state_nxt = SHIFT;
                end
            end
            FLUSH:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= IDLE;
            sh_r       <= {WORD_W{1'b0}};
            last_r     <= 1'b0;
            bit_cnt_r  <= {BC_W{1'b0}};
            hist_r     <= {(PAT_MAX-1){1'b0}};
            hist_cnt_r <= {LEN_W{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            pat_r      <= {PAT_MAX{1'b0}};
            len_r      <= {LEN_W{1'b0}};
            ovl_r      <= 1'b0;
            word_ready <= 1'b0;
            bit_out    <= 1'b0;
            bit_valid  <= 1'b0;
            match      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_r    <= state_nxt;
            sh_r       <= sh_nxt;
            last_r     <= last_nxt;
            bit_cnt_r  <= bit_cnt_nxt;
            hist_r     <= hist_nxt;
            hist_cnt_r <= hist_cnt_nxt;
            cnt_r      <= cnt_nxt;
            pat_r      <= pat_nxt;
            len_r      <= len_nxt;
            ovl_r      <= ovl_nxt;
            word_ready <= (state_nxt == FETCH);
            bit_out    <= (state_nxt == SHIFT) & sh_nxt[WORD_W-1];
            bit_valid  <= (state_nxt == SHIFT);
            match      <= hit_s;
            busy       <= (state_nxt != IDLE);
            done       <= (state_nxt == DONE);
        end
    end

    assign match_cnt = cnt_r;

`ifdef FIRST_MATCH_POS_EN
    logic [15:0] pos_cnt_r;

    // Frame bit index and capture of the first match position.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pos_cnt_r <= 16'h0000;
            first_pos <= 16'h0000;
            first_vld <= 1'b0;
        end else if ((state_r == IDLE) && start) begin
            pos_cnt_r <= 16'h0000;
            first_pos <= 16'h0000;
            first_vld <= 1'b0;
        end else if (state_r == SHIFT) begin
            if (hit_s && !first_vld) begin
                first_pos <= pos_cnt_r;
                first_vld <= 1'b1;
            end
            if (pos_cnt_r != 16'hFFFF) begin
                pos_cnt_r <= pos_cnt_r + 16'h0001;
            end
        end
    end
`endif

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Scoreboard bench for seq_detect_ctrl: frames push expected results, a monitor checks at done.
module tb_seq_detect_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cfg_we = 1'b0;
    logic [7:0] cfg_pattern = 8'h00;
    logic [3:0] cfg_len = 4'd0;
    logic       cfg_overlap = 1'b0;
    logic       start = 1'b0;
    logic       word_valid = 1'b0;
    logic [7:0] word_data = 8'h00;
    logic       word_last = 1'b0;
    logic       word_ready, bit_out, bit_valid, match, busy, done;
    logic [7:0] match_cnt;
`ifdef FIRST_MATCH_POS_EN
    logic [15:0] first_pos;
    logic        first_vld;
`endif

    seq_detect_ctrl dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .start(start),
        .word_valid(word_valid), .word_data(word_data), .word_last(word_last),
        .word_ready(word_ready), .bit_out(bit_out), .bit_valid(bit_valid),
        .match(match), .match_cnt(match_cnt), .busy(busy), .done(done)
`ifdef FIRST_MATCH_POS_EN
        , .first_pos(first_pos), .first_vld(first_vld)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  cnt;
        int          pulses;
        logic [31:0] bits;
        int          nbits;
        int          first;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [7:0]  words[0:31];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: reconstructs the bit stream and match pulses, compares at done.
    int          mon_pulses = 0;
    int          mon_nbits = 0;
    int          mon_first = -1;
    int          mon_last = -1;
    logic [31:0] mon_bits = 32'h0;
    always @(negedge clk) begin
        if (!rst) begin
            mon_pulses = 0; mon_nbits = 0; mon_first = -1; mon_last = -1; mon_bits = 32'h0;
        end else begin
            if (match === 1'b1) begin
                mon_pulses++;
                if (mon_first < 0) mon_first = mon_last;
            end
            if (bit_valid === 1'b1) begin
                mon_bits = {mon_bits[30:0], bit_out};
                mon_last = mon_nbits;
                mon_nbits++;
            end
            if (done === 1'b1) begin
                if (q.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("match_cnt", 64'(match_cnt), 64'(e.cnt));
                    check("match_pulses", 64'(mon_pulses), 64'(e.pulses));
                    check("bit_stream", 64'(mon_bits), 64'(e.bits));
                    check("bit_count", 64'(mon_nbits), 64'(e.nbits));
                    check("first_match_idx", 64'(mon_first), 64'(e.first));
                    check("busy_at_done", 64'(busy), 64'd1);
`ifdef FIRST_MATCH_POS_EN
                    check("first_vld", 64'(first_vld), 64'(e.first >= 0));
                    if (e.first >= 0) check("first_pos", 64'(first_pos), 64'(e.first));
`endif
                end
                mon_pulses = 0; mon_nbits = 0; mon_first = -1; mon_last = -1; mon_bits = 32'h0;
            end
        end
    end

    task automatic push_exp(input logic [7:0] cnt, input int pulses, input logic [31:0] bits,
                            input int nbits, input int first);
        exp_t e;
        e.cnt = cnt; e.pulses = pulses; e.bits = bits; e.nbits = nbits; e.first = first;
        q.push_back(e);
    endtask

    task automatic send_word(input logic [7:0] data, input logic last, input int gap);
        for (int k = 0; k < 200 && word_ready !== 1'b1; k++) @(negedge clk);
        if (word_ready !== 1'b1) check("ready_timeout", 64'(word_ready), 64'd1);
        for (int g = 0; g < gap; g++) begin
            check("no_bubble", 64'(bit_valid), 64'd0);
            @(negedge clk);
        end
        word_valid = 1'b1; word_data = data; word_last = last;
        @(negedge clk);
        word_valid = 1'b0; word_last = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 3000 && busy !== 1'b0; k++) @(negedge clk);
        check("idle_timeout", 64'(busy), 64'd0);
        @(negedge clk);
    endtask

    task automatic run_frame(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                             input int nw, input int gap, input logic do_cfg);
        @(negedge clk);
        cfg_we = do_cfg; cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl; start = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0; start = 1'b0;
        for (int i = 0; i < nw; i++) send_word(words[i], (i == nw - 1), (i == 0) ? 0 : gap);
        wait_idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int dones;
        repeat (2) @(negedge clk);
        check("rst_word_ready", 64'(word_ready), 64'd0);
        check("rst_bit_valid", 64'(bit_valid), 64'd0);
        check("rst_bit_out", 64'(bit_out), 64'd0);
        check("rst_match", 64'(match), 64'd0);
        check("rst_match_cnt", 64'(match_cnt), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // Non-overlapping and overlapping on 10010010
        words[0] = 8'b10010010;
        push_exp(8'd1, 1, 32'h92, 8, 3);
        run_frame(8'h09, 4'd4, 1'b0, 1, 0, 1'b1);
        push_exp(8'd2, 2, 32'h92, 8, 3);
        run_frame(8'h09, 4'd4, 1'b1, 1, 0, 1'b1);

        // Match spanning a word boundary with a 5-cycle producer gap
        words[0] = 8'b00000010; words[1] = 8'b10000000;
        push_exp(8'd1, 1, 32'h0280, 16, 8);
        run_frame(8'h05, 4'd3, 1'b0, 2, 5, 1'b1);

        // Counter saturation: 256 single-bit matches
        for (int i = 0; i < 32; i++) words[i] = 8'hFF;
        push_exp(8'd255, 256, 32'hFFFF_FFFF, 256, 0);
        run_frame(8'h01, 4'd1, 1'b0, 32, 0, 1'b1);

        // Length clamp: len=15 behaves as len=8
        words[0] = 8'hB3; words[1] = 8'hB3;
        push_exp(8'd2, 2, 32'hB3B3, 16, 7);
        run_frame(8'hB3, 4'd15, 1'b1, 2, 0, 1'b1);
        push_exp(8'd2, 2, 32'hB3B3, 16, 7);
        run_frame(8'hB3, 4'd8, 1'b1, 2, 0, 1'b1);

        // len=0 disables detection
        words[0] = 8'hFF;
        push_exp(8'd0, 0, 32'hFF, 8, -1);
        run_frame(8'hFF, 4'd0, 1'b0, 1, 0, 1'b1);

        // Reset in the middle of SHIFT
        @(negedge clk);
        cfg_we = 1'b1; cfg_pattern = 8'h09; cfg_len = 4'd4; cfg_overlap = 1'b0; start = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0; start = 1'b0;
        send_word(8'b10010010, 1'b1, 0);
        repeat (5) @(negedge clk);
        check("pre_rst_cnt", 64'(match_cnt), 64'd1);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_cnt", 64'(match_cnt), 64'd0);
        check("mid_rst_bit_valid", 64'(bit_valid), 64'd0);
        rst = 1'b1;
        dones = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        check("no_done_after_rst", 64'(dones), 64'd0);

        words[0] = 8'b10010010;
        push_exp(8'd2, 2, 32'h92, 8, 3);
        run_frame(8'h09, 4'd4, 1'b1, 1, 0, 1'b1);

        // start/cfg_we during SHIFT must be ignored
        push_exp(8'd1, 1, 32'h92, 8, 3);
        @(negedge clk);
        cfg_we = 1'b1; cfg_pattern = 8'h09; cfg_len = 4'd4; cfg_overlap = 1'b0; start = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0; start = 1'b0;
        send_word(8'b10010010, 1'b1, 0);
        cfg_we = 1'b1; cfg_pattern = 8'h02; cfg_len = 4'd2; cfg_overlap = 1'b1; start = 1'b1;
        repeat (2) @(negedge clk);
        cfg_we = 1'b0; start = 1'b0;
        wait_idle();
        push_exp(8'd1, 1, 32'h92, 8, 3);
        run_frame(8'h02, 4'd2, 1'b1, 1, 0, 1'b0);

        repeat (3) @(negedge clk);
        check("pending_frames", 64'(q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
